elc3_mem_ctrl: RTL and testbench

//  Memory/IO controller between the eLC-3 datapath (MAR/MDR, MIO_EN, R_W) and the board SRAM.

---
 rtl/elc3_mem_pkg.sv | 14 +
 rtl/elc3_mmio_regs.sv | 34 +++
 rtl/elc3_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_elc3_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elc3_mem_pkg.sv
// Shared types and default MMIO addresses for the eLC-3 memory controller.
package elc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mem_state_t;

  localparam logic [15:0] SW_ADDR_DEF  = 16'hFFFF;
  localparam logic [15:0] HEX_ADDR_DEF = 16'hFFFE;

endpackage

// File: rtl/elc3_mmio_regs.sv
// Memory-mapped I/O decode: switch input word and the hex-display register.
module elc3_mmio_regs
  import elc3_mem_pkg::*;
#(
  parameter logic [15:0] SW_ADDR  = SW_ADDR_DEF,
  parameter logic [15:0] HEX_ADDR = HEX_ADDR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_wr_en,
  input  logic [15:0] i_sw,
  output logic        o_is_mmio,
  output logic [15:0] o_rdata,
  output logic [15:0] o_hex
);

  logic [15:0] r_hex;

  assign o_is_mmio = (i_addr == SW_ADDR) || (i_addr == HEX_ADDR);
  assign o_rdata   = (i_addr == SW_ADDR) ? i_sw : r_hex;
  assign o_hex     = r_hex;

  // The switch word is read-only; writes to it are dropped here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hex <= '0;
    end else if (i_wr_en && (i_addr == HEX_ADDR)) begin
      r_hex <= i_wdata;
    end
  end

endmodule

// File: rtl/elc3_mem_ctrl.sv
// eLC-3 memory/IO controller: sequences SRAM reads/writes and services MMIO words.
module elc3_mem_ctrl
  import elc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] SW_ADDR     = SW_ADDR_DEF,
  parameter logic [15:0] HEX_ADDR    = HEX_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Req,
  input  logic        R_W,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  output logic [15:0] RData,
  output logic        Ready,
  input  logic [15:0] SW,
  output logic [15:0] HexOut,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  if (WAIT_CYCLES < 1) begin : g_wait_check
    $error("WAIT_CYCLES must be at least 1");
  end

  localparam int unsigned CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  mem_state_t  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_wr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [19:0] r_sram_addr;
  logic        r_ce_n, r_oe_n, r_we_n, r_bl_n, r_dq_oe, r_ready;
  logic        w_ce_n, w_oe_n, w_we_n, w_bl_n, w_dq_oe, w_ready;
  logic        w_accept, w_wr, w_is_mmio;
  logic [15:0] w_mmio_rdata;

  assign w_accept = (r_state == IDLE) && Req;
  assign w_wr     = w_accept ? R_W : r_wr;

  elc3_mmio_regs #(
    .SW_ADDR  (SW_ADDR),
    .HEX_ADDR (HEX_ADDR)
  ) u_mmio (
    .i_clk     (Clk),
    .i_rst_n   (Reset_N),
    .i_addr    (Addr),
    .i_wdata   (WData),
    .i_wr_en   (w_accept && R_W),
    .i_sw      (SW),
    .o_is_mmio (w_is_mmio),
    .o_rdata   (w_mmio_rdata),
    .o_hex     (HexOut)
  );

  // Strobes are decoded from the state being entered so that every pin is a flop output.
  always_comb begin
    w_next  = r_state;
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_bl_n  = 1'b1;
    w_dq_oe = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      IDLE:    if (Req) w_next = w_is_mmio ? DONE : SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    case (w_next)
      SETUP: begin
        w_ce_n  = 1'b0;
        w_bl_n  = 1'b0;
        w_oe_n  = w_wr;
        w_dq_oe = w_wr;
      end
      ACCESS: begin
        w_ce_n  = 1'b0;
        w_bl_n  = 1'b0;
        w_oe_n  = w_wr;
        w_we_n  = !w_wr;
        w_dq_oe = w_wr;
      end
      DONE: begin
        w_ready = 1'b1;
        w_dq_oe = (r_state == ACCESS) && r_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_bl_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_bl_n  <= w_bl_n;
      r_dq_oe <= w_dq_oe;
      r_ready <= w_ready;
      if (w_accept) begin
        r_wr <= R_W;
        if (!w_is_mmio) r_sram_addr <= {4'b0000, Addr};
        if (w_is_mmio && !R_W) r_rdata <= w_mmio_rdata;
      end
      if (r_state == SETUP) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if ((r_state == ACCESS) && (r_cnt == '0) && !r_wr) r_rdata <= SRAM_DQ;
    end
  end

  // Write data needs no reset: it only reaches the bus while r_dq_oe is set.
  always_ff @(posedge Clk) begin
    if (w_accept) r_wdata <= WData;
  end

  assign SRAM_DQ   = r_dq_oe ? r_wdata : 'z;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_LB_N = r_bl_n;
  assign SRAM_UB_N = r_bl_n;
  assign RData     = r_rdata;
  assign Ready     = r_ready;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
// Self-checking bench for elc3_mem_ctrl with a behavioural asynchronous SRAM on SRAM_DQ.
module tb_elc3_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, r_w;
  logic [15:0] addr, wdata, sw;
  logic [15:0] rdata, hex_out;
  logic        ready;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram_mem [65536];
  logic [15:0] ref_mem [int];
  logic [15:0] ref_hex;
  logic [15:0] ref_rdata;

  always #5 clk = ~clk;

  elc3_mem_ctrl #(
    .WAIT_CYCLES (W),
    .SW_ADDR     (16'hFFFF),
    .HEX_ADDR    (16'hFFFE)
  ) dut (
    .Clk       (clk),
    .Reset_N   (rst_n),
    .Req       (req),
    .R_W       (r_w),
    .Addr      (addr),
    .WData     (wdata),
    .RData     (rdata),
    .Ready     (ready),
    .SW        (sw),
    .HexOut    (hex_out),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n),
    .SRAM_LB_N (lb_n),
    .SRAM_UB_N (ub_n)
  );

  // SRAM device: drives the bus while selected with output enable, stores while WE_N is low.
  assign sram_dq = (!ce_n && !oe_n) ? sram_mem[sram_addr[15:0]] : 'z;
  always @(posedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr[15:0]] <= sram_dq;
  end

  function automatic void model_apply(input logic rw, input logic [15:0] a,
                                      input logic [15:0] wd, input logic [15:0] s);
    if (a == 16'hFFFF) begin
      if (!rw) ref_rdata = s;
    end else if (a == 16'hFFFE) begin
      if (rw) ref_hex = wd;
      else    ref_rdata = ref_hex;
    end else if (rw) begin
      ref_mem[int'(a)] = wd;
    end else begin
      ref_rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'hxxxx;
    end
  endfunction

  function automatic int exp_lat(input logic [15:0] a);
    return ((a == 16'hFFFF) || (a == 16'hFFFE)) ? 0 : W + 1;
  endfunction

  // lat counts clock edges after the edge that samples Req until Ready is seen.
  task automatic do_access(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat, output int we_lo,
                           output int oe_lo, output int ce_lo, output int dq_bad,
                           output logic [19:0] addr0, output logic rdy_after);
    @(negedge clk);
    req = 1'b1; r_w = rw; addr = a; wdata = wd;
    @(posedge clk); #1;
    lat = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; dq_bad = 0;
    addr0 = sram_addr;
    forever begin
      we_lo += int'(!we_n);
      oe_lo += int'(!oe_n);
      ce_lo += int'(!ce_n);
      if (rw && (sram_dq !== wd)) dq_bad++;
      if (ready || lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
    rd  = rdata;
    req = 1'b0;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    req = 1'b0; r_w = 1'b0; addr = '0; wdata = '0; sw = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes: got %b expected 11111", {ce_n, oe_n, we_n, lb_n, ub_n});
    end
    checks++;
    if ({ready, rdata, hex_out, sram_addr} !== 53'h0) begin
      errors++; $display("FAIL reset_outputs: ready=%b rdata=%h hex=%h addr=%h expected all zero", ready, rdata, hex_out, sram_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    ref_hex = 16'h0; ref_rdata = 16'h0;
  endtask

  task automatic test_sram_write();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    do_access(1'b1, 16'h3000, 16'h1234, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b1, 16'h3000, 16'h1234, sw);
    checks++;
    if (a0 !== 20'h03000) begin errors++; $display("FAIL wr_addr: got %h expected 03000", a0); end
    checks++;
    if (we_lo !== W) begin errors++; $display("FAIL wr_we_width: got %0d expected %0d", we_lo, W); end
    checks++;
    if (oe_lo !== 0 || ce_lo !== W + 1) begin
      errors++; $display("FAIL wr_oe_ce: oe_low=%0d ce_low=%0d expected 0 and %0d", oe_lo, ce_lo, W + 1);
    end
    checks++;
    if (dq_bad !== 0) begin errors++; $display("FAIL wr_dq_hold: got %0d bad cycles expected 0", dq_bad); end
    checks++;
    if (lat !== exp_lat(16'h3000)) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, exp_lat(16'h3000)); end
    checks++;
    if (ra !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse: got %b expected 0", ra); end
  endtask

  task automatic test_sram_read();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    do_access(1'b0, 16'h3000, 16'hDEAD, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'h3000, 16'hDEAD, sw);
    checks++;
    if (rd !== ref_rdata) begin errors++; $display("FAIL rd_data: got %h expected %h", rd, ref_rdata); end
    checks++;
    if (oe_lo !== W + 1 || we_lo !== 0) begin
      errors++; $display("FAIL rd_strobes: oe_low=%0d we_low=%0d expected %0d and 0", oe_lo, we_lo, W + 1);
    end
    checks++;
    if (lat !== exp_lat(16'h3000)) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, exp_lat(16'h3000)); end
    checks++;
    if (rdata !== ref_rdata) begin errors++; $display("FAIL rd_hold: got %h expected %h", rdata, ref_rdata); end
  endtask

  task automatic test_mmio();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    sw = 16'hBEEF;
    do_access(1'b0, 16'hFFFF, 16'h0, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'hFFFF, 16'h0, sw);
    checks++;
    if (rd !== ref_rdata) begin errors++; $display("FAIL mmio_sw_read: got %h expected %h", rd, ref_rdata); end
    checks++;
    if (lat !== 0 || ce_lo !== 0) begin errors++; $display("FAIL mmio_sw_timing: lat=%0d ce_low=%0d expected 0 and 0", lat, ce_lo); end
    do_access(1'b1, 16'hFFFE, 16'h00A5, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b1, 16'hFFFE, 16'h00A5, sw);
    checks++;
    if (hex_out !== ref_hex) begin errors++; $display("FAIL mmio_hex_write: got %h expected %h", hex_out, ref_hex); end
    checks++;
    if (lat !== 0 || we_lo !== 0) begin errors++; $display("FAIL mmio_hex_timing: lat=%0d we_low=%0d expected 0 and 0", lat, we_lo); end
    do_access(1'b0, 16'hFFFE, 16'h0, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'hFFFE, 16'h0, sw);
    checks++;
    if (rd !== ref_rdata) begin errors++; $display("FAIL mmio_hex_read: got %h expected %h", rd, ref_rdata); end
    do_access(1'b1, 16'hFFFF, 16'h1111, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b1, 16'hFFFF, 16'h1111, sw);
    checks++;
    if (hex_out !== ref_hex || rd !== ref_rdata || lat !== 0) begin
      errors++; $display("FAIL mmio_sw_write_ignored: hex=%h rdata=%h lat=%0d expected %h %h 0", hex_out, rd, lat, ref_hex, ref_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    @(negedge clk);
    req = 1'b1; r_w = 1'b1; addr = 16'h4000; wdata = 16'h5A5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (we_n !== 1'b0 || sram_dq !== 16'h5A5A) begin
      errors++; $display("FAIL mid_access_active: we_n=%b dq=%h expected 0 and 5a5a", we_n, sram_dq);
    end
    #2; rst_n = 1'b0; req = 1'b0;
    #1;
    checks++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111 || sram_dq === 16'h5A5A) begin
      errors++; $display("FAIL async_reset_bus: strobes=%b dq=%h expected 11111 and undriven", {ce_n, oe_n, we_n, lb_n, ub_n}, sram_dq);
    end
    checks++;
    if (ready !== 1'b0 || rdata !== 16'h0 || hex_out !== 16'h0) begin
      errors++; $display("FAIL async_reset_regs: ready=%b rdata=%h hex=%h expected 0 0 0", ready, rdata, hex_out);
    end
    ref_hex = 16'h0; ref_rdata = 16'h0; ref_mem.delete(int'(16'h4000));
    @(negedge clk); rst_n = 1'b1;
    do_access(1'b0, 16'h3000, 16'h0, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'h3000, 16'h0, sw);
    checks++;
    if (rd !== ref_rdata || lat !== exp_lat(16'h3000)) begin
      errors++; $display("FAIL post_reset_read: data=%h lat=%0d expected %h %0d", rd, lat, ref_rdata, exp_lat(16'h3000));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    int pulses = 0;
    int first = -1;
    int second = -1;
    @(negedge clk);
    req = 1'b1; r_w = 1'b1; addr = 16'h0001; wdata = 16'hA001;
    @(posedge clk);
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      if (ready) begin
        pulses++;
        if (pulses == 1) begin first = cyc; addr = 16'h0002; wdata = 16'hB002; end
        else if (pulses == 2) begin second = cyc; req = 1'b0; end
      end
      @(posedge clk);
    end
    req = 1'b0;
    model_apply(1'b1, 16'h0001, 16'hA001, sw);
    model_apply(1'b1, 16'h0002, 16'hB002, sw);
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++;
    if (first !== W + 1 || second !== 2 * W + 4) begin
      errors++; $display("FAIL b2b_timing: ready at %0d and %0d expected %0d and %0d", first, second, W + 1, 2 * W + 4);
    end
    do_access(1'b0, 16'h0001, 16'h0, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'h0001, 16'h0, sw);
    checks++;
    if (rd !== ref_rdata) begin errors++; $display("FAIL b2b_read1: got %h expected %h", rd, ref_rdata); end
    do_access(1'b0, 16'h0002, 16'h0, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
    model_apply(1'b0, 16'h0002, 16'h0, sw);
    checks++;
    if (rd !== ref_rdata) begin errors++; $display("FAIL b2b_read2: got %h expected %h", rd, ref_rdata); end
  endtask

  task automatic test_random();
    logic [15:0] rd; int lat, we_lo, oe_lo, ce_lo, dq_bad; logic [19:0] a0; logic ra;
    logic [15:0] a, wd;
    logic rw;
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom);
      a  = 16'h3000 + 16'(i);
      do_access(1'b1, a, wd, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
      model_apply(1'b1, a, wd, sw);
    end
    for (int i = 0; i < 40; i++) begin
      sw = 16'($urandom);
      wd = 16'($urandom);
      rw = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    a = 16'hFFFF;
        2, 3:    a = 16'hFFFE;
        default: a = 16'h3000 + 16'($urandom_range(0, 15));
      endcase
      do_access(rw, a, wd, rd, lat, we_lo, oe_lo, ce_lo, dq_bad, a0, ra);
      model_apply(rw, a, wd, sw);
      checks++;
      if (rd !== ref_rdata || hex_out !== ref_hex) begin
        errors++; $display("FAIL rand_data[%0d]: a=%h rw=%b rdata=%h hex=%h expected %h %h", i, a, rw, rd, hex_out, ref_rdata, ref_hex);
      end
      checks++;
      if (lat !== exp_lat(a) || ra !== 1'b0) begin
        errors++; $display("FAIL rand_timing[%0d]: a=%h lat=%0d ready_after=%b expected %0d 0", i, a, lat, ra, exp_lat(a));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_sram_write();
    test_sram_read();
    test_mmio();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
